// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the immediate generator pipeline
package imm_pkg;
  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_ZIMM, IMM_SHAMT, IMM_RSVD
  } imm_src_e;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
  localparam int INSTR_LSB = 7;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational RISC-V immediate decode and extension
module imm_extract import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:INSTR_LSB] instr,
  input  imm_src_e            imm_src,
  output logic [XLEN-1:0]     imm,
  output logic                illegal
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_extract: XLEN must be 32 or 64");
  end
  always_comb begin
    illegal = imm_src == IMM_RSVD;
    case (imm_src)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      IMM_SHAMT: imm = XLEN'({XLEN == 64 && instr[25], instr[24:20]});
      default:   imm = '0;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator behind a 2-entry skid buffer with flush
module imm_gen_pipe import imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic            imm_illegal
);
  skid_state_e     state;
  logic [XLEN-1:0] x_imm, m_imm, k_imm;
  logic            x_ill, m_ill, k_ill, acc, take;
  imm_extract #(.XLEN(XLEN)) u_ext (
    .instr(instr),
    .imm_src(imm_src_e'(imm_src)),
    .imm(x_imm),
    .illegal(x_ill)
  );
  assign in_ready    = state != TWO && !rst;
  assign out_valid   = state != EMPTY;
  assign acc         = in_valid && in_ready;
  assign take        = out_valid && out_ready;
  assign imm_ext     = out_valid ? m_imm : '0;
  assign imm_illegal = out_valid && m_ill;
  always_ff @(posedge clk) begin
    if (rst || flush) state <= EMPTY;
    else case (state)
      EMPTY:   if (acc) state <= ONE;
      ONE:     if (acc && !take) state <= TWO;
               else if (take && !acc) state <= EMPTY;
      default: if (take) state <= ONE;
    endcase
  end
  // Data registers are qualified by state, so they carry no reset
  always_ff @(posedge clk) begin
    if (acc && (state == EMPTY || take)) {m_imm, m_ill} <= {x_imm, x_ill};
    else if (state == TWO && take) {m_imm, m_ill} <= {k_imm, k_ill};
    if (acc && state == ONE && !take) {k_imm, k_ill} <= {x_imm, x_ill};
  end
endmodule
